// File: rtl/fsm_seq_detect_if.sv
// fsm_seq_detect_if: symbol stream, pattern-config and counter-control bus for fsm_seq_detect.
interface fsm_seq_detect_if #(
   parameter int SYM_W = 2,
   parameter int DEPTH = 3
);
   logic                     enable;
   logic                     sym_valid;
   logic [SYM_W-1:0]         sym;
   logic                     cfg_we;
   logic [$clog2(DEPTH)-1:0] cfg_idx;
   logic [SYM_W-1:0]         cfg_sym;
   logic                     cnt_clr;
   modport master (output enable, sym_valid, sym, cfg_we, cfg_idx, cfg_sym, cnt_clr);
   modport slave  (input  enable, sym_valid, sym, cfg_we, cfg_idx, cfg_sym, cnt_clr);
endinterface

// File: rtl/fsm_seq_detect.sv
// fsm_seq_detect: programmable DEPTH-symbol sequence detector with saturating match counter.
// Define FSM_SEQ_HOLD_EN to let a repeat of the last matched symbol hold progress.
module fsm_seq_detect #(
   parameter int SYM_W = 2,
   parameter int DEPTH = 3,
   parameter int CNT_W = 8,
   localparam int PW = $clog2(DEPTH + 1),
   localparam int IW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   fsm_seq_detect_if.slave  bus,
   output logic [PW-1:0]    progress,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt
);
   typedef enum logic [1:0] {ADVANCE, HOLD, RESTART, CLEAR} step_t;
   logic [SYM_W-1:0] pat [DEPTH];
   step_t            step_kind;
   logic             step, at_end, adv, hold, restart, match_nxt, cfg_ok;
   logic [IW-1:0]    idx_cur;
   logic [PW-1:0]    progress_nxt;
   logic [CNT_W-1:0] cnt_base, cnt_nxt;
   assign step    = bus.enable & bus.sym_valid & ~bus.cfg_we;
   assign at_end  = progress == PW'(DEPTH);
   assign idx_cur = at_end ? '0 : IW'(progress);
   assign adv     = !at_end && bus.sym == pat[idx_cur];
   assign restart = bus.sym == pat[0];
   assign cfg_ok  = 32'(bus.cfg_idx) < DEPTH;
`ifdef FSM_SEQ_HOLD_EN
   logic [IW-1:0] idx_prv;
   assign idx_prv = IW'(progress - 1'b1);
   assign hold    = progress != '0 && bus.sym == pat[idx_prv];
`else
   assign hold = 1'b0;
`endif
   always_comb begin
      step_kind    = adv ? ADVANCE : hold ? HOLD : restart ? RESTART : CLEAR;
      progress_nxt = progress;
      if (bus.cfg_we)
         progress_nxt = '0;
      else if (step)
         progress_nxt = step_kind == ADVANCE ? progress + 1'b1 :
                        step_kind == HOLD    ? progress :
                        step_kind == RESTART ? PW'(1) : '0;
      // only an advance out of DEPTH-1 enters DEPTH; holding there never re-pulses
      match_nxt = step && step_kind == ADVANCE && progress == PW'(DEPTH - 1);
      cnt_base  = bus.cnt_clr ? '0 : match_cnt;
      cnt_nxt   = match_nxt && cnt_base != '1 ? cnt_base + 1'b1 : cnt_base;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         progress  <= '0;
         match     <= 1'b0;
         match_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) pat[i] <= SYM_W'(i + 1);
      end else begin
         progress  <= progress_nxt;
         match     <= match_nxt;
         match_cnt <= cnt_nxt;
         if (bus.cfg_we && cfg_ok) pat[bus.cfg_idx] <= bus.cfg_sym;
      end
   end
   assert property (@(posedge clk) disable iff (!reset) progress <= PW'(DEPTH));
endmodule

// File: tb/tb_fsm_seq_detect.sv
// tb_fsm_seq_detect: directed-vector bench for fsm_seq_detect (default DUT plus a CNT_W=2 instance).
module tb_fsm_seq_detect;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   int         checks = 0;
   int         failures = 0;
   logic [1:0] prog, prog2, cnt2;
   logic       mat, mat2;
   logic [7:0] cnt;

   fsm_seq_detect_if #(.SYM_W(2), .DEPTH(3)) bus ();

   fsm_seq_detect u_dut (
      .clk(clk), .reset(reset), .bus(bus),
      .progress(prog), .match(mat), .match_cnt(cnt)
   );

   fsm_seq_detect #(.CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .bus(bus),
      .progress(prog2), .match(mat2), .match_cnt(cnt2)
   );

   always #5 clk = ~clk;

   task automatic apply(input logic [1:0] s, input logic v, input logic e, input logic clr);
      @(negedge clk);
      bus.sym = s;
      bus.sym_valid = v;
      bus.enable = e;
      bus.cnt_clr = clr;
      bus.cfg_we = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [1:0] idx, input logic [1:0] s);
      @(negedge clk);
      bus.cfg_we = 1'b1;
      bus.cfg_idx = idx;
      bus.cfg_sym = s;
      bus.sym = s;
      bus.sym_valid = 1'b1;
      bus.enable = 1'b1;
      bus.cnt_clr = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      @(negedge clk);
      reset = 1'b0;
      bus.sym_valid = 1'b0;
      bus.cfg_we = 1'b0;
      bus.cnt_clr = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (prog !== 2'd0) begin failures++; $display("FAIL reset_progress got=%0d exp=0", prog); end
      checks++; if (mat !== 1'b0) begin failures++; $display("FAIL reset_match got=%0d exp=0", mat); end
      checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
      @(negedge clk);
      reset = 1'b1;
      apply(2'd0, 1'b0, 1'b1, 1'b0);
      checks++; if (prog !== 2'd0 || mat !== 1'b0) begin failures++; $display("FAIL reset_release progress=%0d match=%0d exp 0/0", prog, mat); end
   endtask

   task automatic test_basic;
      logic [1:0] ep [3] = '{2'd1, 2'd2, 2'd3};
      logic       em [3] = '{1'b0, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply(ep[i], 1'b1, 1'b1, 1'b0);
         checks++; if (prog !== ep[i]) begin failures++; $display("FAIL basic_progress[%0d] got=%0d exp=%0d", i, prog, ep[i]); end
         checks++; if (mat !== em[i]) begin failures++; $display("FAIL basic_match[%0d] got=%0d exp=%0d", i, mat, em[i]); end
      end
      checks++; if (cnt !== 8'd1) begin failures++; $display("FAIL basic_cnt got=%0d exp=1", cnt); end
      apply(2'd3, 1'b0, 1'b1, 1'b0);
      checks++; if (prog !== 2'd3 || mat !== 1'b0) begin failures++; $display("FAIL basic_idle progress=%0d match=%0d exp 3/0", prog, mat); end
   endtask

   task automatic test_hold;
      logic [1:0] s  [5] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
`ifdef FSM_SEQ_HOLD_EN
      logic [1:0] ep [5] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
      logic       em [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [7:0] ec = 8'd1;
`else
      logic [1:0] ep [5] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
      logic       em [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [7:0] ec = 8'd0;
`endif
      do_reset();
      for (int i = 0; i < 5; i++) begin
         apply(s[i], 1'b1, 1'b1, 1'b0);
         checks++; if (prog !== ep[i]) begin failures++; $display("FAIL hold_progress[%0d] got=%0d exp=%0d", i, prog, ep[i]); end
         checks++; if (mat !== em[i]) begin failures++; $display("FAIL hold_match[%0d] got=%0d exp=%0d", i, mat, em[i]); end
      end
      checks++; if (cnt !== ec) begin failures++; $display("FAIL hold_cnt got=%0d exp=%0d", cnt, ec); end
   endtask

   task automatic test_restart;
      logic [1:0] s  [4] = '{2'd1, 2'd2, 2'd1, 2'd0};
      logic [1:0] ep [4] = '{2'd1, 2'd2, 2'd1, 2'd0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply(s[i], 1'b1, 1'b1, 1'b0);
         checks++; if (prog !== ep[i] || mat !== 1'b0) begin failures++; $display("FAIL restart[%0d] progress=%0d match=%0d exp %0d/0", i, prog, mat, ep[i]); end
      end
   endtask

   task automatic test_freeze;
      logic [1:0] s  [8] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
      logic       v  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic       e  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [1:0] ep [8] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
      logic       em [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         apply(s[i], v[i], e[i], 1'b0);
         checks++; if (prog !== ep[i] || mat !== em[i]) begin failures++; $display("FAIL freeze[%0d] progress=%0d match=%0d exp %0d/%0d", i, prog, mat, ep[i], em[i]); end
      end
   endtask

   task automatic test_cfg;
      logic       k  [16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [1:0] a  [16] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd3, 2'd3, 2'd0, 2'd3};
      logic [1:0] b  [16] = '{2'd3, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
      logic [1:0] ep [16] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
      logic       em [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 16; i++) begin
         if (k[i]) cfg(a[i], b[i]);
         else apply(a[i], 1'b1, 1'b1, 1'b0);
         checks++; if (prog !== ep[i] || mat !== em[i]) begin failures++; $display("FAIL cfg[%0d] progress=%0d match=%0d exp %0d/%0d", i, prog, mat, ep[i], em[i]); end
      end
      checks++; if (cnt !== 8'd2) begin failures++; $display("FAIL cfg_cnt got=%0d exp=2", cnt); end
   endtask

   task automatic test_saturate;
      logic [1:0] ec2;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         apply(2'((i % 3) + 1), 1'b1, 1'b1, 1'b0);
         if (i % 3 == 2) begin
            ec2 = (i / 3 + 1) > 3 ? 2'd3 : 2'(i / 3 + 1);
            checks++; if (cnt2 !== ec2 || mat2 !== 1'b1) begin failures++; $display("FAIL sat_cnt[%0d] cnt=%0d match=%0d exp %0d/1", i, cnt2, mat2, ec2); end
         end
      end
      checks++; if (cnt !== 8'd4) begin failures++; $display("FAIL sat_wide_cnt got=%0d exp=4", cnt); end
      apply(2'd1, 1'b1, 1'b1, 1'b0);
      apply(2'd2, 1'b1, 1'b1, 1'b0);
      apply(2'd3, 1'b1, 1'b1, 1'b1);
      checks++; if (cnt2 !== 2'd1 || cnt !== 8'd1 || mat !== 1'b1) begin failures++; $display("FAIL clr_on_match cnt2=%0d cnt=%0d match=%0d exp 1/1/1", cnt2, cnt, mat); end
      apply(2'd0, 1'b0, 1'b1, 1'b1);
      checks++; if (cnt2 !== 2'd0 || cnt !== 8'd0) begin failures++; $display("FAIL clr_alone cnt2=%0d cnt=%0d exp 0/0", cnt2, cnt); end
      apply(2'd1, 1'b1, 1'b1, 1'b0);
      apply(2'd2, 1'b1, 1'b1, 1'b0);
      apply(2'd3, 1'b1, 1'b1, 1'b0);
      apply(2'd1, 1'b1, 1'b1, 1'b0);
      apply(2'd2, 1'b1, 1'b1, 1'b0);
      checks++; if (prog !== 2'd2 || cnt !== 8'd1) begin failures++; $display("FAIL pre_async progress=%0d cnt=%0d exp 2/1", prog, cnt); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (prog !== 2'd0 || prog2 !== 2'd0 || cnt !== 8'd0 || mat !== 1'b0) begin failures++; $display("FAIL async_reset progress=%0d progress2=%0d cnt=%0d match=%0d exp 0/0/0/0", prog, prog2, cnt, mat); end
      bus.sym_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      bus.enable = 1'b0;
      bus.sym_valid = 1'b0;
      bus.sym = 2'd0;
      bus.cfg_we = 1'b0;
      bus.cfg_idx = 2'd0;
      bus.cfg_sym = 2'd0;
      bus.cnt_clr = 1'b0;
      test_reset();
      test_basic();
      test_hold();
      test_restart();
      test_freeze();
      test_cfg();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
